// File: rtl/ram_responder.sv
// Word-addressed RAM responder with configurable wait states and a busy/done/err handshake.
// Rejected requests take one cycle through the access slot, so their response latency does not depend on WAIT_CYCLES.
module ram_responder #(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        Read,
  input  logic        Write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] Mdatain,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                bad_q;
  logic                write_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdata_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;

  logic [31:0]         mem [DEPTH];

  logic                upper_ok_c;
  logic                reject_c;

  // Requests outside the RAM window or with both strobes set are rejected.
  assign upper_ok_c = (addr >> ADDR_W) == 32'd0;
  assign reject_c   = (Read && Write) || !upper_ok_c;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bad_q   <= 1'b0;
      write_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Read || Write) begin
            busy_q  <= 1'b1;
            write_q <= Write;
            idx_q   <= addr[ADDR_W-1:0];
            wdata_q <= wdata;
            cnt_q   <= WAIT_INIT;
            bad_q   <= reject_c;
            if (reject_c || (WAIT_CYCLES == 0)) begin
              state_q <= S_ACCESS;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_q <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (!bad_q && !write_q) begin
            rdata_q <= mem[idx_q];
          end
          done_q  <= 1'b1;
          err_q   <= bad_q;
          state_q <= S_RESP;
        end
        S_RESP: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          bad_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // RAM array has no reset; a write commits only on its access edge.
  always_ff @(posedge clk) begin
    if ((state_q == S_ACCESS) && !bad_q && write_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign Mdatain = rdata_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: four instances with different wait-state counts, a
// cycle-level request model checked every cycle, plus directed literal expectations.
module tb_ram_responder;

  localparam int NI = 4;

  logic        clk = 1'b0;
  logic        clr;
  logic        rd [NI];
  logic        wr [NI];
  logic [31:0] ad [NI];
  logic [31:0] wd [NI];
  logic [31:0] md [NI];
  logic        bz [NI];
  logic        dn [NI];
  logic        er [NI];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ram_responder #(.ADDR_W(9), .WAIT_CYCLES(2)) u0 (
    .clk(clk), .clr(clr), .Read(rd[0]), .Write(wr[0]), .addr(ad[0]), .wdata(wd[0]),
    .Mdatain(md[0]), .busy(bz[0]), .done(dn[0]), .err(er[0]));
  ram_responder #(.ADDR_W(9), .WAIT_CYCLES(0)) u1 (
    .clk(clk), .clr(clr), .Read(rd[1]), .Write(wr[1]), .addr(ad[1]), .wdata(wd[1]),
    .Mdatain(md[1]), .busy(bz[1]), .done(dn[1]), .err(er[1]));
  ram_responder #(.ADDR_W(9), .WAIT_CYCLES(1)) u2 (
    .clk(clk), .clr(clr), .Read(rd[2]), .Write(wr[2]), .addr(ad[2]), .wdata(wd[2]),
    .Mdatain(md[2]), .busy(bz[2]), .done(dn[2]), .err(er[2]));
  ram_responder #(.ADDR_W(9), .WAIT_CYCLES(7)) u3 (
    .clk(clk), .clr(clr), .Read(rd[3]), .Write(wr[3]), .addr(ad[3]), .wdata(wd[3]),
    .Mdatain(md[3]), .busy(bz[3]), .done(dn[3]), .err(er[3]));

  function automatic int wc(input int i);
    case (i)
      0:       return 2;
      1:       return 0;
      2:       return 1;
      default: return 7;
    endcase
  endfunction

  // Request-level model: each accepted request is one record with the edge at
  // which it takes effect; outputs follow from that record.
  int          cyc = 0;
  logic        m_act  [NI];
  logic        m_done [NI];
  logic        m_err  [NI];
  logic        m_perr [NI];
  logic        m_pwr  [NI];
  logic [8:0]  m_pa   [NI];
  logic [31:0] m_pd   [NI];
  logic [31:0] m_md   [NI];
  int          m_acc  [NI];
  logic [31:0] mmem   [NI][512];

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < NI; i++) begin
        m_act[i]  = 1'b0;
        m_done[i] = 1'b0;
        m_err[i]  = 1'b0;
        m_md[i]   = 32'h0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        m_done[i] = 1'b0;
        m_err[i]  = 1'b0;
        if (m_act[i]) begin
          if (cyc == m_acc[i]) begin
            if (!m_perr[i]) begin
              if (m_pwr[i]) mmem[i][m_pa[i]] = m_pd[i];
              else          m_md[i] = mmem[i][m_pa[i]];
            end
            m_done[i] = 1'b1;
            m_err[i]  = m_perr[i];
          end else if (cyc == m_acc[i] + 1) begin
            m_act[i] = 1'b0;
          end
        end else if (rd[i] || wr[i]) begin
          m_perr[i] = (rd[i] && wr[i]) || (ad[i][31:9] != 23'd0);
          m_pwr[i]  = wr[i];
          m_pa[i]   = ad[i][8:0];
          m_pd[i]   = wd[i];
          m_acc[i]  = cyc + (m_perr[i] ? 1 : wc(i) + 1);
          m_act[i]  = 1'b1;
        end
      end
      cyc = cyc + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic cmp_all();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("u%0d busy", i), 32'(bz[i]), 32'(m_act[i]));
      chk($sformatf("u%0d done", i), 32'(dn[i]), 32'(m_done[i]));
      chk($sformatf("u%0d err", i),  32'(er[i]), 32'(m_err[i]));
      chk($sformatf("u%0d Mdatain", i), md[i], m_md[i]);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cmp_all();
    #1;
  endtask

  task automatic check_zero(input string nm);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s u%0d busy", nm, i), 32'(bz[i]), 32'd0);
      chk($sformatf("%s u%0d done", nm, i), 32'(dn[i]), 32'd0);
      chk($sformatf("%s u%0d err", nm, i),  32'(er[i]), 32'd0);
      chk($sformatf("%s u%0d Mdatain", nm, i), md[i], 32'd0);
    end
  endtask

  // Present a request for one edge, then scramble addr/wdata.
  task automatic start(input int i, input logic r, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    rd[i] = r;
    wr[i] = w;
    ad[i] = a;
    wd[i] = d;
    tick();
    rd[i] = 1'b0;
    wr[i] = 1'b0;
    ad[i] = 32'hFFFF_FFFF;
    wd[i] = ~d;
  endtask

  // Latency counts edges from accept to the edge that first samples done high.
  task automatic wait_done(input int i, input int exp_lat, input logic exp_err,
                           input logic [31:0] exp_md, input string nm);
    int cnt;
    int bc;
    cnt = 1;
    bc  = bz[i] ? 1 : 0;
    while (!dn[i] && cnt < 40) begin
      tick();
      cnt++;
      if (bz[i]) bc++;
    end
    chk({nm, " latency"}, 32'(cnt), 32'(exp_lat));
    chk({nm, " busy cycles"}, 32'(bc), 32'(exp_lat));
    chk({nm, " err"}, 32'(er[i]), 32'(exp_err));
    chk({nm, " data"}, md[i], exp_md);
    tick();
  endtask

  task automatic run(input int i, input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input int exp_lat, input logic exp_err,
                     input logic [31:0] exp_md, input string nm);
    start(i, r, w, a, d);
    wait_done(i, exp_lat, exp_err, exp_md, nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dcount;
    clr = 1'b0;
    for (int i = 0; i < NI; i++) begin
      rd[i] = 1'b0;
      wr[i] = 1'b0;
      ad[i] = 32'h0;
      wd[i] = 32'h0;
    end
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset");
    clr = 1'b1;
    tick();

    // Round trip with two wait states.
    run(0, 1'b0, 1'b1, 32'h05, 32'hDEAD_BEEF, 4, 1'b0, 32'h0,         "rt write");
    run(0, 1'b1, 1'b0, 32'h05, 32'h0,         4, 1'b0, 32'hDEAD_BEEF, "rt read");

    // Latency sweep for 0, 1 and 7 wait states.
    run(1, 1'b0, 1'b1, 32'h20, 32'hA5A5_0001, 2, 1'b0, 32'h0,         "w0 write");
    run(1, 1'b1, 1'b0, 32'h20, 32'h0,         2, 1'b0, 32'hA5A5_0001, "w0 read");
    run(2, 1'b0, 1'b1, 32'h20, 32'hA5A5_0002, 3, 1'b0, 32'h0,         "w1 write");
    run(2, 1'b1, 1'b0, 32'h20, 32'h0,         3, 1'b0, 32'hA5A5_0002, "w1 read");
    run(3, 1'b0, 1'b1, 32'h20, 32'hA5A5_0003, 9, 1'b0, 32'h0,         "w7 write");
    run(3, 1'b1, 1'b0, 32'h20, 32'h0,         9, 1'b0, 32'hA5A5_0003, "w7 read");

    // Illegal requests leave RAM and Mdatain alone.
    run(0, 1'b0, 1'b1, 32'h10,        32'h7777_7777, 4, 1'b0, 32'hDEAD_BEEF, "wr10");
    run(0, 1'b1, 1'b1, 32'h10,        32'h9999_9999, 2, 1'b1, 32'hDEAD_BEEF, "both strobes");
    run(0, 1'b1, 1'b0, 32'h10,        32'h0,         4, 1'b0, 32'h7777_7777, "rd10");
    run(0, 1'b1, 1'b0, 32'h0000_0200, 32'h0,         2, 1'b1, 32'h7777_7777, "addr 0x200");
    run(3, 1'b1, 1'b1, 32'h20,        32'h0,         2, 1'b1, 32'hA5A5_0003, "w7 both strobes");

    // A write presented during WAIT of a read is dropped.
    run(0, 1'b0, 1'b1, 32'h03, 32'hAAAA_5555, 4, 1'b0, 32'h7777_7777, "wr3");
    start(0, 1'b1, 1'b0, 32'h05, 32'h0);
    start(0, 1'b0, 1'b1, 32'h03, 32'h0000_1234);
    dcount = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (dn[0]) dcount++;
    end
    chk("busy-ignore done pulses", 32'(dcount), 32'd1);
    chk("busy-ignore rd5 data", md[0], 32'hDEAD_BEEF);
    run(0, 1'b1, 1'b0, 32'h03, 32'h0, 4, 1'b0, 32'hAAAA_5555, "rd3 after ignored write");

    // Reset during WAIT of a write discards it.
    run(0, 1'b0, 1'b1, 32'h07, 32'h1111_1111, 4, 1'b0, 32'hAAAA_5555, "wr7 old");
    start(0, 1'b0, 1'b1, 32'h07, 32'hCAFE_F00D);
    clr = 1'b0;
    #1;
    check_zero("mid-write reset");
    #2;
    clr = 1'b1;
    tick();
    run(0, 1'b1, 1'b0, 32'h07, 32'h0, 4, 1'b0, 32'h1111_1111, "rd7 after reset");

    // Read presented in the first IDLE cycle after the write completes.
    run(0, 1'b0, 1'b1, 32'h01, 32'h1357_2468, 4, 1'b0, 32'h1111_1111, "b2b write");
    run(0, 1'b1, 1'b0, 32'h01, 32'h0,         4, 1'b0, 32'h1357_2468, "b2b read");

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
